ppm_byte_assembler: RTL and testbench

- Downstream of the 4-PPM 2-bit symbol slicer.
- Consumes its {invalid, 2-bit data} symbol word and one-cycle finish strobe, and packs four consecutive symbols MSB-first into a byte.
- Presents each byte on a valid/ready handshake to the frame/FIFO stage.
- Flags symbol timeouts, invalid symbols and output overruns; counts bytes per frame.

---
 rtl/ppm_byte_assembler.sv | 118 +++++++++++
 tb/tb_ppm_byte_assembler.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/ppm_byte_assembler.sv
// Packs four 2-bit 4-PPM symbols MSB-first into a byte and hands it to the
// next stage over valid/ready. Reports symbol errors, overruns and counts bytes per frame.
module ppm_byte_assembler #(
  parameter int SYM_TIMEOUT = 24,
  parameter int TO_W        = 5
) (
  input  logic       clk16,
  input  logic       rst,
  input  logic       frame_en,
  input  logic [2:0] sym_in,
  input  logic       sym_finish,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  input  logic       byte_ready,
  output logic       sym_err,
  output logic       overrun,
  input  logic       err_clr,
  output logic [7:0] byte_cnt
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(SYM_TIMEOUT - 1);

  logic [1:0]      sym_idx_reg;
  logic [5:0]      shift_reg;
  logic [TO_W-1:0] to_cnt_reg;
  logic            frame_en_d_reg;
  logic [7:0]      byte_out_reg;
  logic            byte_valid_reg;
  logic            sym_err_reg;
  logic            overrun_reg;
  logic [7:0]      byte_cnt_reg;

  logic       accept;
  logic       invalid;
  logic       timeout;
  logic       complete;
  logic       frame_start;
  logic       out_free;
  logic [7:0] full_byte;
  logic [7:0] cnt_inc;

  always_comb begin
    accept      = frame_en && sym_finish && !sym_in[2];
    invalid     = frame_en && sym_finish && sym_in[2];
    timeout     = frame_en && (sym_idx_reg != 2'd0) && !sym_finish &&
                  (to_cnt_reg == TO_LAST);
    complete    = accept && (sym_idx_reg == 2'd3);
    frame_start = frame_en && !frame_en_d_reg;
    out_free    = !byte_valid_reg || byte_ready;
    full_byte   = {shift_reg, sym_in[1:0]};
    cnt_inc     = (byte_cnt_reg == 8'hFF) ? 8'hFF : byte_cnt_reg + 8'd1;
  end

  // Symbol packing and inter-symbol timeout.
  always_ff @(posedge clk16) begin
    if (rst) begin
      sym_idx_reg    <= 2'd0;
      shift_reg      <= 6'd0;
      to_cnt_reg     <= '0;
      frame_en_d_reg <= 1'b0;
      sym_err_reg    <= 1'b0;
    end else begin
      frame_en_d_reg <= frame_en;
      sym_err_reg    <= invalid || timeout;
      if (!frame_en || invalid || timeout) begin
        sym_idx_reg <= 2'd0;
        shift_reg   <= 6'd0;
        to_cnt_reg  <= '0;
      end else if (accept) begin
        to_cnt_reg <= '0;
        if (sym_idx_reg == 2'd3) begin
          sym_idx_reg <= 2'd0;
          shift_reg   <= 6'd0;
        end else begin
          sym_idx_reg <= sym_idx_reg + 2'd1;
          shift_reg   <= {shift_reg[3:0], sym_in[1:0]};
        end
      end else if (sym_idx_reg != 2'd0) begin
        to_cnt_reg <= to_cnt_reg + 1'b1;
      end else begin
        to_cnt_reg <= '0;
      end
    end
  end

  // Output register, overrun flag and per-frame byte counter.
  always_ff @(posedge clk16) begin
    if (rst) begin
      byte_out_reg   <= 8'h00;
      byte_valid_reg <= 1'b0;
      overrun_reg    <= 1'b0;
      byte_cnt_reg   <= 8'h00;
    end else begin
      if (complete && out_free) begin
        byte_out_reg   <= full_byte;
        byte_valid_reg <= 1'b1;
        byte_cnt_reg   <= frame_start ? 8'd1 : cnt_inc;
      end else begin
        if (byte_valid_reg && byte_ready)
          byte_valid_reg <= 1'b0;
        if (frame_start)
          byte_cnt_reg <= 8'd0;
      end
      // A drop in the same cycle as err_clr keeps the flag set.
      if (complete && !out_free)
        overrun_reg <= 1'b1;
      else if (err_clr)
        overrun_reg <= 1'b0;
    end
  end

  assign byte_out   = byte_out_reg;
  assign byte_valid = byte_valid_reg;
  assign sym_err    = sym_err_reg;
  assign overrun    = overrun_reg;
  assign byte_cnt   = byte_cnt_reg;

endmodule

// File: tb/tb_ppm_byte_assembler.sv
// Directed bench for ppm_byte_assembler: inputs driven and outputs sampled on
// the falling edge, expected values hand-computed from the symbol sequences.
module tb_ppm_byte_assembler;

  logic       clk16 = 1'b0;
  logic       rst = 1'b1;
  logic       frame_en = 1'b0;
  logic [2:0] sym_in = 3'd0;
  logic       sym_finish = 1'b0;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       byte_ready = 1'b1;
  logic       sym_err;
  logic       overrun;
  logic       err_clr = 1'b0;
  logic [7:0] byte_cnt;

  int tests_run = 0;
  int tests_failed = 0;

  ppm_byte_assembler #(.SYM_TIMEOUT(24), .TO_W(5)) dut (
    .clk16      (clk16),
    .rst        (rst),
    .frame_en   (frame_en),
    .sym_in     (sym_in),
    .sym_finish (sym_finish),
    .byte_out   (byte_out),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .sym_err    (sym_err),
    .overrun    (overrun),
    .err_clr    (err_clr),
    .byte_cnt   (byte_cnt)
  );

  always #5 clk16 = ~clk16;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("[TB] ok %s = 0x%0h", tag, got);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk16);
  endtask

  // Called on a falling edge; returns on the falling edge after the strobe was sampled.
  task automatic send_sym(input logic [2:0] s);
    sym_in     = s;
    sym_finish = 1'b1;
    @(negedge clk16);
    sym_finish = 1'b0;
    sym_in     = 3'd0;
  endtask

  // Four symbols, 8 cycles apart, MSB pair first; returns right after the 4th.
  task automatic send_byte(input logic [7:0] b);
    for (int k = 3; k >= 0; k--) begin
      logic [7:0] t;
      t = b >> (2 * k);
      send_sym({1'b0, t[1:0]});
      if (k != 0) idle(7);
    end
  endtask

  initial begin
    idle(2);
    check("reset byte_out", byte_out, 8'h00);
    check("reset byte_valid", byte_valid, 0);
    check("reset sym_err", sym_err, 0);
    check("reset overrun", overrun, 0);
    check("reset byte_cnt", byte_cnt, 0);
    rst = 1'b0;
    frame_en = 1'b1;
    idle(3);

    // Basic byte: 01 11 00 10
    send_sym(3'b001); idle(7);
    send_sym(3'b011); idle(7);
    send_sym(3'b000); idle(7);
    check("t1 no valid before 4th", byte_valid, 0);
    send_sym(3'b010);
    check("t1 byte_out", byte_out, 8'h72);
    check("t1 byte_valid", byte_valid, 1);
    check("t1 byte_cnt", byte_cnt, 1);
    check("t1 sym_err", sym_err, 0);
    idle(1);
    check("t1 valid one cycle", byte_valid, 0);
    idle(6);

    // Backpressure and overrun
    byte_ready = 1'b0;
    send_byte(8'hE4);
    check("t2 first byte", byte_out, 8'hE4);
    check("t2 first valid", byte_valid, 1);
    check("t2 no overrun yet", overrun, 0);
    idle(7);
    send_byte(8'h1B);
    check("t2 held byte", byte_out, 8'hE4);
    check("t2 still valid", byte_valid, 1);
    check("t2 overrun", overrun, 1);
    check("t2 byte_cnt", byte_cnt, 2);
    byte_ready = 1'b1;
    idle(1);
    check("t2 consumed", byte_valid, 0);
    check("t2 overrun sticky", overrun, 1);
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
    check("t2 overrun cleared", overrun, 0);
    idle(6);

    // Invalid symbol discards partial byte
    send_sym(3'b011); idle(7);
    send_sym(3'b000); idle(7);
    send_sym(3'b100);
    check("t3 sym_err pulse", sym_err, 1);
    check("t3 no byte", byte_valid, 0);
    idle(1);
    check("t3 sym_err one cycle", sym_err, 0);
    idle(6);
    send_byte(8'hFF);
    check("t3 byte_out", byte_out, 8'hFF);
    check("t3 byte_valid", byte_valid, 1);
    check("t3 byte_cnt", byte_cnt, 3);
    idle(8);

    // Timeout 24 cycles after the accept
    send_sym(3'b001);
    idle(23);
    check("t4 no early timeout", sym_err, 0);
    idle(1);
    check("t4 timeout pulse", sym_err, 1);
    idle(1);
    check("t4 pulse one cycle", sym_err, 0);
    idle(6);
    send_byte(8'h87);
    check("t4 no stale symbol", byte_out, 8'h87);
    check("t4 byte_cnt", byte_cnt, 4);
    idle(8);

    // Frame drop mid-byte, then restart
    send_sym(3'b011); idle(7);
    send_sym(3'b011); idle(7);
    send_sym(3'b011); idle(7);
    frame_en = 1'b0;
    idle(1);
    check("t5 silent discard", sym_err, 0);
    frame_en = 1'b1;
    idle(1);
    check("t5 cnt cleared", byte_cnt, 0);
    idle(6);
    send_byte(8'h55);
    check("t5 byte_out", byte_out, 8'h55);
    check("t5 byte_cnt", byte_cnt, 1);
    check("t5 sym_err", sym_err, 0);
    idle(8);

    // Reset with a partial byte and a held output byte
    byte_ready = 1'b0;
    send_byte(8'hAA);
    idle(7);
    send_sym(3'b001); idle(7);
    send_sym(3'b001); idle(3);
    check("t6 valid before rst", byte_valid, 1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    byte_ready = 1'b1;
    check("t6 rst byte_out", byte_out, 8'h00);
    check("t6 rst byte_valid", byte_valid, 0);
    check("t6 rst byte_cnt", byte_cnt, 0);
    check("t6 rst overrun", overrun, 0);
    idle(3);
    send_byte(8'hCC);
    check("t6 clean byte", byte_out, 8'hCC);
    check("t6 clean cnt", byte_cnt, 1);
    check("t6 sym_err", sym_err, 0);
    idle(4);

    // Back-to-back strobes on consecutive cycles: 01 10 11 00
    send_sym(3'b001);
    send_sym(3'b010);
    send_sym(3'b011);
    send_sym(3'b000);
    check("t7 burst byte", byte_out, 8'h6C);
    check("t7 burst valid", byte_valid, 1);
    check("t7 burst cnt", byte_cnt, 2);
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
